arbiter_4: RTL
==============

# arbiter_4

Four-requester arbiter that shares one downstream resource between up to four clients. It resolves simultaneous requests using the same priority convention as the team's 4x2 priority encoder, where the highest index wins. It holds the grant until the owner releases it, and enforces a maximum hold time. It sits between the request sources and the shared resource, and drives that resource's select lines through `gnt_id`.

## Interface
- `HOLD_MAX`, default 15: maximum cycles a grant may be held; legal range 1..(2^CNT_W − 1).
- `CNT_W`, default 4: width of the hold counter.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req`  in  4  request vector; `req[i]` high = client i wants the resource.
- `done`  in  1  current owner releases the resource; ignored when no grant is active.
- `gnt`  out  4  one-hot grant vector; all zero when idle.
- `gnt_id`  out  2  binary index of the granted client; 0 when idle.
- `valid`  out  1  high while any grant is active; equals `|gnt`.
- `timeout`  out  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- Reset values: `gnt`=0000, `gnt_id`=00, `valid`=0, `timeout`=0, state=IDLE, hold counter=0, priority pointer `ptr`=3.
- States:
  - IDLE. If `req`≠0, select a winner and go to GRANT. If `req`=0, stay in IDLE.
  - GRANT. Outputs are held constant. Return to IDLE on the first of these release conditions:
    - `done`=1.
    - `req[owner]`=0 (implicit release).
    - hold counter = `HOLD_MAX` (forced release).
- Winner selection, fixed priority (macro off): highest set bit of `req`. Examples: 0101→2, 1010→3, 1100→3, 0001→0.
- Winner selection, rotating priority (macro on): search starts at index `ptr` and descends, wrapping from 0 to 3. The first set bit wins.
- `ptr` update on every release of owner k: `ptr` = (k−1) mod 4, so k=0 gives 3. In fixed mode `ptr` is kept but unused.
- Hold counter:
  - Loaded with 1 on entry to GRANT.
  - Increments each GRANT cycle.
  - Saturates; never wraps.
  - Cleared in IDLE.
- Forced release: when the counter reaches `HOLD_MAX` and neither `done` nor an implicit release is present at that edge, the arbiter returns to IDLE. `timeout`=1 for exactly the first IDLE cycle.
- Simultaneous `done` and limit at the same edge: treated as a normal release, with `timeout`=0.
- Requests from non-owners during GRANT are ignored. There is no preemption.
- `done` while IDLE has no effect.
- Every grant is followed by at least one IDLE cycle with `gnt`=0.

## Timing
- Grant latency: `req` sampled at edge n while in IDLE → `gnt` and `gnt_id` valid after edge n. The first grant cycle is n→n+1.
- Release latency: release condition sampled at edge m → `gnt`=0 after edge m.
- Back-to-back: the earliest next grant is registered at edge m+1, giving a one-cycle gap.
- Maximum grant length: `HOLD_MAX` cycles, including the first grant cycle.
- Reset mid-grant: `rst` high at edge r → all outputs at reset values after edge r, `ptr`=3. `rst` has priority over every other input.
- All outputs are registered. There are no combinational paths from `req` or `done` to the outputs.

## Configuration
- `ARB_ROUND_ROBIN_EN`:
  - Defined: rotating priority via `ptr` as described under Operation.
  - Undefined: fixed priority, bit 3 highest, identical to the priority-encoder ordering. `ptr` logic may be removed by synthesis.
  - Reset behaviour and the first arbitration after reset are identical in both builds, because `ptr`=3.

## Test plan
- Single requester: `req`=0100 held, `done` pulsed on the 3rd grant cycle → `gnt`=0100, `gnt_id`=10, `valid`=1 for 3 cycles. Then one IDLE cycle. Then re-grant to 0100.
- Fixed priority (macro off): `req`=1010, then 0101, then 1100, with `done` after 1 cycle each → grants 1000, 0100, 1000, in that order. `req`=0000 → stays IDLE with all outputs 0.
- Round robin (macro on): `req`=1111 held, `done` every 2nd grant cycle → grant order 3,2,1,0,3. Each grant is separated by exactly one IDLE cycle.
- Timeout: `HOLD_MAX`=4, `req`=0001 held, no `done` → `gnt`=0001 for exactly 4 cycles, then `timeout`=1 for one cycle with `gnt`=0. Repeat with `done` on the 4th cycle → `timeout` stays 0.
- Implicit release and ignored requests: owner 2 granted, `req` changes 0100→1000 → `gnt` drops to 0 after that edge, then `gnt`=1000 one cycle later.
- Reset mid-grant: `rst` pulsed during the 2nd grant cycle with `req`=1111 held → outputs cleared after that edge. Next grant goes to client 3 in both builds.

Source files
------------

// File: rtl/arbiter_4.sv
// arbiter_4: four-client hold-until-release arbiter with hold limit; define ARB_ROUND_ROBIN_EN for rotating priority
module arbiter_4 #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       valid,
    output logic       timeout
);
    typedef enum logic {IDLE, GRANT} state_t;
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       id_q, id_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       base, idx, win;
    logic             found, at_lim, rel;
`ifdef ARB_ROUND_ROBIN_EN
    assign base = ptr_q;
`else
    assign base = 2'd3;
`endif
    assign at_lim = cnt_q == HOLD_LIM;
    assign rel    = done || !req[id_q] || at_lim;
    // descending search from base with wrap; first set bit wins
    always_comb begin
        idx   = base;
        win   = 2'd0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = base - 2'(i);
            if (req[idx] && !found) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end
    // next state, registered outputs, hold counter and priority pointer
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (found) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << win;
                    id_d    = win;
                    cnt_d   = CNT_W'(1);
                end
            end
            default: begin
                if (rel) begin
                    state_d   = IDLE;
                    gnt_d     = 4'b0000;
                    id_d      = 2'd0;
                    cnt_d     = '0;
                    ptr_d     = id_q - 2'd1;
                    timeout_d = at_lim && !done && req[id_q];
                end else begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
        endcase
        valid_d = |gnt_d;
    end
    // state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= 4'b0000;
            id_q      <= 2'd0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            ptr_q     <= 2'd3;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            id_q      <= id_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
        end
    end
    assign gnt     = gnt_q;
    assign gnt_id  = id_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;
endmodule
